// File: rtl/pid_pwm_out.sv
// pid_pwm_out - output stage of the time-multiplexed PID controller.
//
// Takes the signed motor power word m_k. The word arrives one channel at a
// time under the address a. This block drives one sign/magnitude PWM plus
// direction pair per H-bridge. A new value is captured on the rising edge of
// ce. It becomes active only at the next PWM period wrap, so the duty never
// changes in the middle of a period. A direction reversal first holds the
// bridge off for dt clocks of dead time.
//
// Ports:
//   clk_pid  in   1   clock shared with the PID stage
//   reset_n  in   1   asynchronous active-low reset
//   ce       in   1   PID data-available strobe; only its rising edge matters
//   a        in   aw  channel address of m_k
//   m_k      in   ow  signed motor power (two's complement)
//   pwm_out  out  an  per-channel PWM (magnitude)
//   dir_out  out  an  per-channel direction, 1 = negative m_k
//   sync     out  1   one-cycle pulse on the last count of every PWM period
//
// Optional build macro: PID_PWM_WATCHDOG_EN.
//   Defined: a channel that receives no new capture for wd PWM periods has its
//   magnitude forced to 0 at the following wrap.
//   Undefined: the last captured value is driven indefinitely.

module pid_pwm_out #(
    parameter int aw = 1,
    parameter int an = 2**aw,
    parameter int ow = 12,
    parameter int dt = 8,
    parameter int wd = 4
) (
    input  logic          clk_pid,
    input  logic          reset_n,
    input  logic          ce,
    input  logic [aw-1:0] a,
    input  logic [ow-1:0] m_k,
    output logic [an-1:0] pwm_out,
    output logic [an-1:0] dir_out,
    output logic          sync
);
    localparam int mw = ow - 1;
    localparam logic [mw-1:0] MAX     = {mw{1'b1}};
    localparam logic [mw-1:0] LAST    = MAX - 1'b1;
    localparam logic [mw-1:0] DT_LOAD = mw'(dt - 1);

    if (dt < 1 || dt > 2**mw - 2) begin : g_dt_range
        $error("pid_pwm_out: dt out of range");
    end
    if (wd < 1) begin : g_wd_range
        $error("pid_pwm_out: wd must be at least 1");
    end

    typedef enum logic {RUN = 1'b0, DEAD = 1'b1} state_t;

    // Shared PWM counter and capture strobe
    logic [mw-1:0] cnt_q, cnt_d;
    logic          ce_q;
    logic          wrap;
    logic          cap;

    assign wrap  = (cnt_q == LAST);
    assign cnt_d = wrap ? '0 : cnt_q + 1'b1;
    assign cap   = ce & ~ce_q;
    assign sync  = wrap;

    always_ff @(posedge clk_pid or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce;
        end
    end

    // Sign/magnitude conversion of the incoming word. The most negative value
    // has no positive counterpart, so it saturates to full scale.
    logic [ow-1:0] neg_mk;
    logic [mw-1:0] in_mag;
    logic          in_sign;

    always_comb begin
        neg_mk  = -m_k;
        in_sign = m_k[ow-1];
        if (!in_sign) begin
            in_mag = m_k[mw-1:0];
        end else if (m_k[mw-1:0] == '0) begin
            in_mag = MAX;
        end else begin
            in_mag = neg_mk[mw-1:0];
        end
    end

    for (genvar gi = 0; gi < an; gi++) begin : g_ch
        logic [mw-1:0] pend_mag_q, pend_mag_d;
        logic          pend_sign_q, pend_sign_d;
        logic [mw-1:0] act_mag_q, act_mag_d;
        logic          act_sign_q, act_sign_d;
        logic [mw-1:0] dcnt_q, dcnt_d;
        logic          dir_q, dir_d;
        logic          pwm_q, pwm_d;
        state_t        state_q, state_d;
        logic          sel;
        logic [mw-1:0] load_mag;
        logic          load_sign;

        assign sel = cap && (a == aw'(gi));

`ifdef PID_PWM_WATCHDOG_EN
        localparam int WCW = $clog2(wd + 1);
        logic [WCW-1:0] wdc_q, wdc_d;
        logic           starve;

        // Counts wraps since the last capture and saturates at wd.
        assign starve = (wdc_q == WCW'(wd));

        always_comb begin
            wdc_d = wdc_q;
            if (sel) begin
                wdc_d = '0;
            end else if (wrap && !starve) begin
                wdc_d = wdc_q + 1'b1;
            end
        end
`endif

        always_comb begin
            pend_mag_d  = pend_mag_q;
            pend_sign_d = pend_sign_q;
            act_mag_d   = act_mag_q;
            act_sign_d  = act_sign_q;
            state_d     = state_q;
            dcnt_d      = dcnt_q;
            dir_d       = dir_q;
            load_mag    = pend_mag_q;
            load_sign   = pend_sign_q;

`ifdef PID_PWM_WATCHDOG_EN
            if (wrap && starve) begin
                load_mag   = '0;
                pend_mag_d = '0;
            end
`endif
            // A capture on the wrap cycle lands in pending only. Active still
            // takes the old pending value, so the new word waits a full period.
            if (sel) begin
                pend_mag_d  = in_mag;
                pend_sign_d = in_sign;
            end
            if (wrap) begin
                act_mag_d  = load_mag;
                act_sign_d = load_sign;
            end

            case (state_q)
                RUN: begin
                    // A zero magnitude never reverses the bridge.
                    if (wrap && (load_mag != '0) && (load_sign != dir_q)) begin
                        state_d = DEAD;
                        dcnt_d  = DT_LOAD;
                    end
                end
                DEAD: begin
                    if (dcnt_q == '0) begin
                        state_d = RUN;
                        dir_d   = act_sign_q;
                    end else begin
                        dcnt_d = dcnt_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase

            // The next state gates the PWM. pwm_out is therefore already low
            // on the cycle after the wrap that starts the dead time.
            pwm_d = (state_d == RUN) && (cnt_q < act_mag_q);
        end

        always_ff @(posedge clk_pid or negedge reset_n) begin
            if (!reset_n) begin
                pend_mag_q  <= '0;
                pend_sign_q <= 1'b0;
                act_mag_q   <= '0;
                act_sign_q  <= 1'b0;
                state_q     <= RUN;
                dcnt_q      <= '0;
                dir_q       <= 1'b0;
                pwm_q       <= 1'b0;
`ifdef PID_PWM_WATCHDOG_EN
                wdc_q       <= '0;
`endif
            end else begin
                pend_mag_q  <= pend_mag_d;
                pend_sign_q <= pend_sign_d;
                act_mag_q   <= act_mag_d;
                act_sign_q  <= act_sign_d;
                state_q     <= state_d;
                dcnt_q      <= dcnt_d;
                dir_q       <= dir_d;
                pwm_q       <= pwm_d;
`ifdef PID_PWM_WATCHDOG_EN
                wdc_q       <= wdc_d;
`endif
            end
        end

        assign pwm_out[gi] = pwm_q;
        assign dir_out[gi] = dir_q;
    end

endmodule

// File: tb/tb_pid_pwm_out.sv
// Testbench for pid_pwm_out with the default parameters (aw=1, ow=12, dt=8).
// A table of captures is applied one per period. The full PWM period that
// follows each capture is measured: high count per channel, the sample index
// of any direction flip, and the final direction. Hand-written sequences
// cover reset, the sync timing, a capture on the wrap cycle and an
// asynchronous reset while the PWM is active.

module tb_pid_pwm_out;
    logic        clk_pid = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce      = 1'b0;
    logic [0:0]  a       = '0;
    logic [11:0] m_k     = '0;
    logic [1:0]  pwm_out;
    logic [1:0]  dir_out;
    logic        sync;

    int n_checks = 0;
    int n_pass   = 0;

    int         m_hi[2];
    int         m_flip[2];
    logic [1:0] m_dir;

    pid_pwm_out dut (
        .clk_pid (clk_pid),
        .reset_n (reset_n),
        .ce      (ce),
        .a       (a),
        .m_k     (m_k),
        .pwm_out (pwm_out),
        .dir_out (dir_out),
        .sync    (sync)
    );

    always #5 clk_pid = ~clk_pid;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns with the sample taken #1 after the edge that shows sync high.
    task automatic wait_sync();
        bit found = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk_pid);
            #1;
            if (sync) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            n_checks++;
            $display("FAIL sync_timeout: got no sync, expected sync within 3000 clocks");
        end
    endtask

    // Call right after sync was seen. Sample k is taken #1 after edge Ek,
    // where E0 is the wrap edge. The highs in samples 1..2047 are the
    // compares for cnt 0..2046 against the newly loaded magnitude.
    task automatic measure();
        logic [1:0] dir_start;
        dir_start = '0;
        m_hi[0] = 0;
        m_hi[1] = 0;
        m_flip[0] = -1;
        m_flip[1] = -1;
        for (int k = 0; k < 2048; k++) begin
            @(posedge clk_pid);
            #1;
            if (k == 0) begin
                dir_start = dir_out;
            end else begin
                for (int c = 0; c < 2; c++) begin
                    if (pwm_out[c]) m_hi[c]++;
                    if (m_flip[c] < 0 && dir_out[c] != dir_start[c]) m_flip[c] = k;
                end
            end
        end
        m_dir = dir_out;
    endtask

    task automatic capture(input int ch, input int val);
        repeat (3) @(posedge clk_pid);
        @(negedge clk_pid);
        a   = 1'(ch);
        m_k = 12'(val);
        ce  = 1'b1;
        @(negedge clk_pid);
        ce  = 1'b0;
    endtask

    typedef struct {
        int         ch;
        int         mk;
        int         hi0;
        int         hi1;
        logic [1:0] dir;
        int         f0;
        int         f1;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        // {channel, m_k, highs ch0, highs ch1, dir {ch1,ch0}, flip k ch0, flip k ch1}
        // A flip zeroes samples 1..7, so the high count is the magnitude minus 7.
        tbl[0]  = '{0,  1023, 1023,    0, 2'b00, -1, -1};
        tbl[1]  = '{1, -2048, 1023, 2040, 2'b10, -1,  8};
        tbl[2]  = '{0,   500,  500, 2047, 2'b10, -1, -1};
        tbl[3]  = '{0,  -500,  493, 2047, 2'b11,  8, -1};
        tbl[4]  = '{0,     0,    0, 2047, 2'b11, -1, -1};
        tbl[5]  = '{1,     1,    0,    0, 2'b01, -1,  8};
        tbl[6]  = '{0,    -1,    1,    1, 2'b01, -1, -1};
        tbl[7]  = '{1,  2047,    1, 2047, 2'b01, -1, -1};
        tbl[8]  = '{1,     0,    1,    0, 2'b01, -1, -1};
        tbl[9]  = '{1,    -7,    1,    0, 2'b11, -1,  8};
        tbl[10] = '{0,  2046, 2039,    7, 2'b10,  8, -1};

        // Reset held while ce toggles and a non-zero word is presented
        m_k = 12'h3FF;
        repeat (10) begin
            @(negedge clk_pid);
            ce = ~ce;
        end
        chk("reset_pwm",  int'(pwm_out), 0);
        chk("reset_dir",  int'(dir_out), 0);
        chk("reset_sync", int'(sync), 0);
        @(negedge clk_pid);
        reset_n = 1'b1;

        n = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_pid);
            #1;
            n++;
            if (sync) break;
        end
        chk("first_sync_clocks", n, 2046);
        @(posedge clk_pid);
        #1;
        chk("sync_width", int'(sync), 0);
        n = 1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk_pid);
            #1;
            n++;
            if (sync) break;
        end
        chk("sync_period", n, 2047);
        $display("reset: first sync after 2046 clocks expected, period %0d", n);

`ifdef PID_PWM_WATCHDOG_EN
        // The first wrap after the capture loads +1000. The watchdog forces
        // zero at the fifth wrap. The windows measured start at wraps 1, 3 and 5.
        capture(0, 1000);
        wait_sync(); measure();
        chk("wd_w1_hi0", m_hi[0], 1000);
        wait_sync(); measure();
        chk("wd_w3_hi0", m_hi[0], 1000);
        wait_sync(); measure();
        chk("wd_w5_hi0", m_hi[0], 0);
        chk("wd_w5_dir", int'(m_dir), 0);
        capture(0, 1000);
        wait_sync(); measure();
        chk("wd_rearm_hi0", m_hi[0], 1000);
        $display("watchdog: rearmed duty %0d", m_hi[0]);
        capture(0, 0);
        wait_sync(); measure();
`endif

        for (int i = 0; i < 11; i++) begin
            capture(tbl[i].ch, tbl[i].mk);
            wait_sync();
            measure();
            $display("vec %0d: ch%0d m_k=%0d hi0=%0d hi1=%0d dir=%b flip=%0d/%0d",
                     i, tbl[i].ch, tbl[i].mk, m_hi[0], m_hi[1], m_dir, m_flip[0], m_flip[1]);
            chk($sformatf("vec%0d_hi0", i),   m_hi[0],     tbl[i].hi0);
            chk($sformatf("vec%0d_hi1", i),   m_hi[1],     tbl[i].hi1);
            chk($sformatf("vec%0d_dir", i),   int'(m_dir), int'(tbl[i].dir));
            chk($sformatf("vec%0d_flip0", i), m_flip[0],   tbl[i].f0);
            chk($sformatf("vec%0d_flip1", i), m_flip[1],   tbl[i].f1);
        end

        // Capture on the wrap cycle: the old value (2046) persists one full
        // period. ce is held high throughout to show that its level is ignored.
        wait_sync();
        a   = 1'b0;
        m_k = 12'd300;
        ce  = 1'b1;
        measure();
        ce  = 1'b0;
        $display("same-cycle capture: first period hi0=%0d", m_hi[0]);
        chk("samecyc_old_hi0", m_hi[0], 2046);
        wait_sync();
        measure();
        $display("same-cycle capture: later period hi0=%0d", m_hi[0]);
        chk("samecyc_new_hi0", m_hi[0], 300);
        chk("samecyc_hi1",     m_hi[1], 7);

        // Asynchronous reset between clock edges while PWM and direction are set
        @(posedge clk_pid);
        #3;
        chk("pre_reset_pwm0", int'(pwm_out[0]), 1);
        chk("pre_reset_dir",  int'(dir_out), 2);
        reset_n = 1'b0;
        #1;
        chk("async_reset_pwm", int'(pwm_out), 0);
        chk("async_reset_dir", int'(dir_out), 0);
        $display("async reset: pwm=%b dir=%b", pwm_out, dir_out);
        #20;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_pid);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pid_pwm_out.md
Name: pid_pwm_out

Overview:
- Downstream stage of the PID controller: consumes the time-multiplexed signed motor power word (m_k), its channel address (a) and the data-available strobe (ce).
- Demultiplexes the word into per-channel registers and drives one sign/magnitude PWM + direction pair per motor H-bridge.
- Inserts dead time on every direction reversal.

Parameters:
- aw, 1, channel address width; must match the PID address width.
- an, 2**aw, number of channels.
- ow, 12, width of signed input word; PWM resolution is ow-1 bits.
- dt, 8, dead-time length in clk_pid cycles; legal range 1..2**(ow-1)-2.
- wd, 4, watchdog timeout in PWM periods (used only with the optional feature).

Ports:
- clk_pid  in  1  clock; same clock as the PID stage.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  PID data-available strobe; high for several clocks per channel slot.
- a  in  aw  channel address of m_k.
- m_k  in  ow  signed motor power (two's complement).
- pwm_out  out  an  per-channel PWM (magnitude).
- dir_out  out  an  per-channel direction; 1 = negative m_k.
- sync  out  1  one-cycle pulse on every PWM period wrap.

Behaviour:
- Reset (asynchronous): all outputs 0; counter 0; pending/active magnitude 0; pending/active sign 0; ce_d 0; all channels in RUN.
- Capture:
  - ce_d is ce registered. The rising edge (ce & ~ce_d) captures m_k into pending[a] in that cycle.
  - The level of ce is otherwise ignored.
- Magnitude = |m_k|; -2**(ow-1) saturates to 2**(ow-1)-1. Sign = m_k[ow-1]. A captured 0 clears the sign.
- PWM counter:
  - cnt, ow-1 bits, counts 0..MAX-1 with MAX = 2**(ow-1)-1, then wraps to 0. Period = MAX clocks.
  - sync = 1 on the cycle cnt == MAX-1.
- Update: on the wrap cycle (cnt == MAX-1), every channel loads active <= pending (both magnitude and sign).
  - The active duty therefore never changes mid-period.
  - If capture and wrap occur in the same cycle, the register update completes but active still loads the old pending value; the new value applies at the next wrap.
- Per-channel FSM, states RUN and DEAD:
  - RUN: pwm_out registered = (cnt < active_mag), so 1 cycle latency from cnt.
    - active_mag = 0 gives constant 0; active_mag = MAX gives constant 1.
    - dir_out = active_sign.
  - RUN -> DEAD: at wrap, when loaded sign != dir_out and loaded magnitude != 0. Zero magnitude never flips dir_out.
  - DEAD: pwm_out forced 0 and dir_out held for dt cycles (per-channel down-counter). On expiry, dir_out <= active_sign and the state returns to RUN.
    - PWM resumes at the current cnt position; the counter never stops.
- Because dt < MAX, DEAD always ends before the next wrap.
- Reset asserted mid-operation: immediate return to reset values, including in DEAD (pwm_out 0 at once).

Optional Feature:
- Macro: PID_PWM_WATCHDOG_EN.
- Defined:
  - Each channel has a period counter, cleared on every capture for that channel and incremented at each wrap.
  - When it reaches wd, that channel's pending and active magnitude are forced to 0 at the next wrap; pwm_out goes 0 and dir_out is held.
  - The next capture re-arms the channel.
- Undefined: no watchdog logic. The last captured value is driven indefinitely.

Test Plan:
- Reset: hold reset_n = 0 with ce toggling -> pwm_out = 0, dir_out = 0, sync = 0; release -> first sync after 2046 clocks.
- ch0 m_k = +1023 captured (a = 0, ce rise) -> from the next wrap, pwm_out[0] high exactly 1023 of 2047 clocks per period, dir_out[0] = 0; ch1 unaffected.
- ch1 m_k = -2048 -> magnitude saturates to 2047, pwm_out[1] constantly 1 after the dead phase; dir_out[1] = 1 only after 8 clocks of pwm_out[1] = 0 following the wrap.
- ch0 +500 then -500 -> at the wrap, pwm_out[0] = 0 for 8 clocks, then dir_out[0] = 1, duty 500; then m_k = 0 -> duty 0, dir_out[0] stays 1.
- Capture on the same cycle as sync -> the old value persists one more full period, then the new value applies.
- With PID_PWM_WATCHDOG_EN, ce stopped after capturing +1000 -> after 4 periods pwm_out = 0; a new capture of +1000 restores duty at the following wrap.
